// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN back-end stages.
//   DATA_W      : width of every feature, weight and score word
//   fc_state_e  : state encoding of the fully-connected classifier FSM
//   clog2()     : ceiling log2, usable in constant expressions
//   sat16()     : clamp a wide signed value into the signed 16-bit range
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_MAC     = 3'd2,
    ST_FIN     = 3'd3,
    ST_OUT     = 3'd4
  } fc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Callers sign-extend into 64 bits so one helper serves any accumulator width.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7fff;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_classifier_if.sv
// Bus bundle between the classifier and its neighbours.
//   master : drives weight words and features (CNN side / loader)
//   slave  : the classifier; drives status, result and debug state
// Handshake: w_valid and in_valid are fire-and-forget strobes with no ready;
// a word is taken on every rising edge where its strobe is high and the
// classifier is in a state that accepts it, otherwise it is dropped.
// out_valid is a one-cycle pulse; out_class/out_score are 0 outside it.
interface fc_classifier_if #(
  parameter int CLS_W = 2
);
  import cnn_pkg::*;

  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              weights_ready;
  logic              out_valid;
  logic [CLS_W-1:0]  out_class;
  logic [DATA_W-1:0] out_score;
  fc_state_e         dbg_state;

  modport master (
    output w_valid, w_data, in_valid, in_data,
    input  busy, weights_ready, out_valid, out_class, out_score, dbg_state
  );

  modport slave (
    input  w_valid, w_data, in_valid, in_data,
    output busy, weights_ready, out_valid, out_class, out_score, dbg_state
  );

endinterface

// File: rtl/fc_classifier_mac_unit.sv
// Multiply-accumulate datapath for one class score.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the accumulator
//   accumulate : acc += feat * weight
//   finalize   : score is valid this cycle; accumulator clears at the edge
//   feat/weight/bias : signed 16-bit operands
//   score      : sat16((acc + bias) >>> SHIFT), combinational
module fc_mac_unit
  import cnn_pkg::*;
#(
  parameter int ACC_W = 36,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accumulate,
  input  logic                     finalize,
  input  logic signed [DATA_W-1:0] feat,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] score
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] feat_ext, weight_ext, bias_ext, prod, sum, shifted;

  always_comb begin
    feat_ext   = {{(ACC_W-DATA_W){feat[DATA_W-1]}}, feat};
    weight_ext = {{(ACC_W-DATA_W){weight[DATA_W-1]}}, weight};
    bias_ext   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    // Operands are pre-extended so the product is exact in ACC_W bits.
    prod       = feat_ext * weight_ext;
    sum        = acc_q + bias_ext;
    shifted    = sum >>> SHIFT;
    score      = sat16({{(64-ACC_W){shifted[ACC_W-1]}}, shifted});
  end

  always_comb begin
    acc_d = acc_q;
    if (clear || finalize) acc_d = '0;
    else if (accumulate)   acc_d = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier behind the CNN pooling stage.
//   clk   : single rising-edge clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : fc_classifier_if.slave -- weight load, feature input, result,
//           busy/weights_ready status and dbg_state
// Weights are stored class-major: w[c][0..NUM_FEAT-1], bias[c]. Each
// inference runs NUM_FEAT MAC cycles plus one finalize cycle per class,
// tracks the running argmax, then pulses out_valid once.
module fc_classifier
  import cnn_pkg::*;
#(
  parameter int NUM_FEAT  = 4,
  parameter int NUM_CLASS = 3,
  parameter int SHIFT     = 0,
  parameter int CLS_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fc_classifier_if.slave  bus
);

  localparam int NWORDS = (NUM_FEAT + 1) * NUM_CLASS;
  localparam int WP_W   = (NWORDS > 1) ? clog2(NWORDS) : 1;
  localparam int FP_W   = (NUM_FEAT > 1) ? clog2(NUM_FEAT) : 1;
  localparam int ACC_W  = 2 * DATA_W + clog2(NUM_FEAT + 1) + 1;

  fc_state_e state_q, state_d;

  logic [WP_W-1:0]   wptr_q, wptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] w_q    [NWORDS];
  logic [DATA_W-1:0] w_d    [NWORDS];
  logic [DATA_W-1:0] feat_q [NUM_FEAT];
  logic [DATA_W-1:0] feat_d [NUM_FEAT];
  logic [FP_W-1:0]   fptr_q, fptr_d;
  logic [CLS_W-1:0]  cls_q, cls_d;
  logic [CLS_W-1:0]  best_cls_q, best_cls_d;
  logic [DATA_W-1:0] best_score_q, best_score_d;

  logic              last_feat, last_class, start_ok;
  logic [WP_W-1:0]   w_idx, b_idx, row_base;
  logic [DATA_W-1:0] mac_feat, mac_weight, mac_bias;
  logic [DATA_W-1:0] score;

  // Row base of the current class in the class-major weight store.
  assign row_base   = WP_W'(cls_q) * WP_W'(NUM_FEAT + 1);
  assign w_idx      = row_base + WP_W'(fptr_q);
  assign b_idx      = row_base + WP_W'(NUM_FEAT);
  assign last_feat  = (fptr_q == FP_W'(NUM_FEAT - 1));
  assign last_class = (cls_q == CLS_W'(NUM_CLASS - 1));
  // A simultaneous weight word takes priority over a feature in IDLE.
  assign start_ok   = bus.in_valid && !bus.w_valid && ready_q;

  assign mac_feat   = feat_q[fptr_q];
  assign mac_weight = w_q[w_idx];
  assign mac_bias   = w_q[b_idx];

  fc_mac_unit #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk        (clk),
    .rst        (rst_n),
    .clear      (state_q == ST_IDLE),
    .accumulate (state_q == ST_MAC),
    .finalize   (state_q == ST_FIN),
    .feat       (mac_feat),
    .weight     (mac_weight),
    .bias       (mac_bias),
    .score      (score)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok) state_d = (NUM_FEAT == 1) ? ST_MAC : ST_COLLECT;
      ST_COLLECT: begin
        if (!bus.in_valid)  state_d = ST_IDLE;
        else if (last_feat) state_d = ST_MAC;
      end
      ST_MAC:     if (last_feat) state_d = ST_FIN;
      ST_FIN:     state_d = last_class ? ST_OUT : ST_MAC;
      ST_OUT:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath register updates.
  always_comb begin
    wptr_d       = wptr_q;
    ready_d      = ready_q;
    w_d          = w_q;
    feat_d       = feat_q;
    fptr_d       = fptr_q;
    cls_d        = cls_q;
    best_cls_d   = best_cls_q;
    best_score_d = best_score_q;
    case (state_q)
      ST_IDLE: begin
        fptr_d = '0;
        cls_d  = '0;
        if (bus.w_valid) begin
          w_d[wptr_q] = bus.w_data;
          if (wptr_q == WP_W'(NWORDS - 1)) begin
            wptr_d  = '0;
            ready_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end else if (start_ok) begin
          feat_d[0] = bus.in_data;
          fptr_d    = (NUM_FEAT == 1) ? '0 : FP_W'(1);
        end
      end
      ST_COLLECT: begin
        if (!bus.in_valid) begin
          fptr_d = '0;
        end else begin
          feat_d[fptr_q] = bus.in_data;
          fptr_d         = last_feat ? '0 : fptr_q + 1'b1;
        end
      end
      ST_MAC: fptr_d = last_feat ? '0 : fptr_q + 1'b1;
      ST_FIN: begin
        // Strictly-greater replace keeps the lowest index on ties.
        if (cls_q == '0 || $signed(score) > $signed(best_score_q)) begin
          best_cls_d   = cls_q;
          best_score_d = score;
        end
        cls_d = last_class ? '0 : cls_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy          = (state_q != ST_IDLE);
    bus.weights_ready = ready_q;
    bus.out_valid     = (state_q == ST_OUT);
    bus.out_class     = (state_q == ST_OUT) ? best_cls_q : '0;
    bus.out_score     = (state_q == ST_OUT) ? best_score_q : '0;
    bus.dbg_state     = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      ready_q      <= 1'b0;
      w_q          <= '{default: '0};
      feat_q       <= '{default: '0};
      fptr_q       <= '0;
      cls_q        <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      ready_q      <= ready_d;
      w_q          <= w_d;
      feat_q       <= feat_d;
      fptr_q       <= fptr_d;
      cls_q        <= cls_d;
      best_cls_q   <= best_cls_d;
      best_score_q <= best_score_d;
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
module tb_fc_classifier;
  import cnn_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [15:0] wbuf [15];

  int          pulses, first_at;
  logic [1:0]  got_cls;
  logic [15:0] got_score;
  logic        busy_seen;

  fc_classifier_if #(.CLS_W(2)) bus ();

  fc_classifier #(
    .NUM_FEAT  (4),
    .NUM_CLASS (3),
    .SHIFT     (0),
    .CLS_W     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_wbuf();
    for (int i = 0; i < 15; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = wbuf[i];
      step();
    end
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
  endtask

  // Leaves the bench in cycle T+1 (T = cycle the last feature is sampled).
  task automatic send_feats(input int n, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    logic [15:0] f [4];
    f[0] = a; f[1] = b; f[2] = c; f[3] = d;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Observes ncyc cycles starting now (cycle index 1 = current cycle).
  task automatic watch(input int ncyc, output int np, output int fa,
                       output logic [1:0] oc, output logic [15:0] os, output logic bs);
    np = 0; fa = 0; oc = '0; os = '0; bs = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      if (bus.out_valid) begin
        if (np == 0) begin
          fa = i;
          oc = bus.out_class;
          os = bus.out_score;
        end
        np++;
      end
      bs = bs | bus.busy;
      step();
    end
  endtask

  task automatic set_t1_weights();
    wbuf = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0,
             16'd0, 16'd1, 16'd0, 16'd0, 16'd0,
             16'd0, 16'd0, 16'd0, 16'd1, 16'd5};
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_class", 32'(bus.out_class), 32'd0);
    chk("rst_out_score", 32'(bus.out_score), 32'd0);
    chk("rst_busy",      32'(bus.busy), 32'd0);
    chk("rst_ready",     32'(bus.weights_ready), 32'd0);
    chk("rst_state",     32'(bus.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b0;
    step();

    // Test 4: features before any weight load are ignored
    send_feats(4, 16'd10, 16'd20, 16'd30, 16'd40);
    watch(40, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t4_pulses", 32'(pulses), 32'd0);
    chk("t4_busy",   32'(busy_seen), 32'd0);
    chk("t4_ready",  32'(bus.weights_ready), 32'd0);

    // Test 1: basic classification and latency
    set_t1_weights();
    load_wbuf();
    chk("t1_ready", 32'(bus.weights_ready), 32'd1);
    send_feats(4, 16'd10, 16'd20, 16'd30, 16'd40);
    watch(16, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t1_pulses",   32'(pulses), 32'd1);
    chk("t1_latency",  32'(first_at), 32'd16);
    chk("t1_class",    32'(got_cls), 32'd2);
    chk("t1_score",    32'(got_score), 32'd45);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    chk("t1_ov_end",   32'(bus.out_valid), 32'd0);
    chk("t1_cls_idle", 32'(bus.out_class), 32'd0);

    // Test 2: ties keep the lowest index
    for (int i = 0; i < 15; i++) wbuf[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
    load_wbuf();
    send_feats(4, 16'd7, 16'd0, 16'd0, 16'd0);
    watch(20, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_class",  32'(got_cls), 32'd0);
    chk("t2_score",  32'(got_score), 32'd7);

    // Test 3: positive and negative saturation
    for (int i = 0; i < 15; i++) wbuf[i] = (i % 5 == 4) ? 16'd0 : 16'h7fff;
    load_wbuf();
    send_feats(4, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    watch(20, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t3_pos_pulses", 32'(pulses), 32'd1);
    chk("t3_pos_score",  32'(got_score), 32'h7fff);
    for (int i = 0; i < 15; i++) wbuf[i] = (i % 5 == 4) ? 16'd0 : 16'h8000;
    load_wbuf();
    send_feats(4, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    watch(20, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t3_neg_pulses", 32'(pulses), 32'd1);
    chk("t3_neg_score",  32'(got_score), 32'h8000);
    chk("t3_neg_class",  32'(got_cls), 32'd0);

    // Test 5: partial burst is discarded, full burst then completes once
    set_t1_weights();
    load_wbuf();
    send_feats(2, 16'd10, 16'd20, 16'd0, 16'd0);
    step();
    chk("t5_abort_idle", 32'(bus.busy), 32'd0);
    send_feats(4, 16'd10, 16'd20, 16'd30, 16'd40);
    watch(30, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t5_pulses",  32'(pulses), 32'd1);
    chk("t5_latency", 32'(first_at), 32'd16);
    chk("t5_class",   32'(got_cls), 32'd2);
    chk("t5_score",   32'(got_score), 32'd45);

    // Test 6: reset in cycle T+5 aborts and clears weights_ready
    send_feats(4, 16'd10, 16'd20, 16'd30, 16'd40);
    for (int i = 0; i < 4; i++) step();
    chk("t6_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("t6_ov",    32'(bus.out_valid), 32'd0);
    chk("t6_cls",   32'(bus.out_class), 32'd0);
    chk("t6_score", 32'(bus.out_score), 32'd0);
    chk("t6_busy",  32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.weights_ready), 32'd0);
    send_feats(4, 16'd10, 16'd20, 16'd30, 16'd40);
    watch(40, pulses, first_at, got_cls, got_score, busy_seen);
    chk("t6_pulses", 32'(pulses), 32'd0);
    chk("t6_busy_after", 32'(busy_seen), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Stage directly downstream of the CNN conv/ReLU/max-pool block.
- Consumes its 4 pooled features, which arrive as consecutive out_valid/out_data samples.
- Applies a fully-connected layer: NUM_CLASS dot products of length NUM_FEAT plus a bias per class.
- Reports the winning class index and its saturated score.
- Weights are loaded serially and held until the next load or reset.

Parameters:
- NUM_FEAT, 4, features per inference; equals the CNN output count.
- NUM_CLASS, 3, number of output classes.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
- CLS_W, 2, width of the class index; must satisfy 2^CLS_W >= NUM_CLASS.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-high reset; asserted = 1.
- w_valid  input  1  weight-load strobe.
- w_data  input  16  signed weight/bias word.
- in_valid  input  1  feature strobe; driven by CNN out_valid.
- in_data  input  16  signed feature; driven by CNN out_data.
- busy  output  1  high whenever state is not IDLE.
- weights_ready  output  1  a complete weight set is loaded.
- out_valid  output  1  one-cycle result pulse.
- out_class  output  CLS_W  argmax class index.
- out_score  output  16  signed saturated score of the winning class.

Behaviour:
- Reset: while rst_n = 1 at an edge, the following clear to 0:
  - all outputs;
  - the weight write pointer and weights_ready;
  - the feature pointer, the accumulator and the argmax registers.
  - State returns to IDLE. Reset mid-operation aborts the inference with no output.
- Weight load (IDLE only):
  - Each w_valid cycle writes one word. Order is class-major: w[c][0..NUM_FEAT-1] followed by bias[c], for c = 0..NUM_CLASS-1.
  - A full set is (NUM_FEAT+1)*NUM_CLASS words (15 at defaults).
  - After the last word, weights_ready is set and the pointer wraps to 0. A later load overwrites words in place, and weights_ready stays 1.
  - w_valid outside IDLE is ignored.
- States: IDLE, COLLECT, MAC, FIN, OUT.
- IDLE:
  - in_valid with weights_ready = 1: capture feature 0, go to COLLECT.
  - in_valid with weights_ready = 0: ignored, stay IDLE.
  - If w_valid and in_valid arrive together, w_valid wins and in_valid is ignored.
- COLLECT:
  - Each in_valid cycle captures the next feature.
  - When feature NUM_FEAT-1 is captured, go to MAC.
  - If in_valid is low before all features arrive: discard the partial features, return to IDLE, no output.
- MAC:
  - One product per cycle: acc += feat[f]*w[c][f].
  - acc is signed, 2*16+CLOG2(NUM_FEAT+1)+1 bits wide (36 at defaults).
  - After f = NUM_FEAT-1, go to FIN.
- FIN (one cycle per class):
  - score = (acc + bias[c]) >>> SHIFT, then saturated to [-32768, 32767].
  - Argmax update: class 0 always loads. A later class replaces the stored best only if its score is strictly greater, so ties keep the lower index.
  - Clear acc. If c < NUM_CLASS-1, increment c and return to MAC; otherwise go to OUT.
- OUT:
  - out_valid = 1 for exactly one cycle, with out_class/out_score equal to the best result.
  - Next state is IDLE.
  - out_class/out_score read 0 whenever out_valid = 0.
- Latency: let T be the cycle in which the last feature is sampled. out_valid is high in cycle T + NUM_CLASS*(NUM_FEAT+1) + 1, which is T+16 at defaults.
- in_valid during MAC/FIN/OUT is ignored. A new inference may start in the cycle immediately after out_valid.
- Features and weights are not modified by an inference. Repeated feature bursts reuse the same weights.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W = 16;
  - the fc state enum;
  - function sat16 (wide signed to 16-bit clamp);
  - the CLOG2 helper.
- One sub-module, fc_mac_unit, owns the multiply-accumulate, bias add, shift and saturation. Its controls are clear, accumulate and finalize.
- The top level keeps the FSM, the weight/feature register files and the argmax.

Test Plan:
1. Weights c0=[1,0,0,0] b0, c1=[0,1,0,0] b0, c2=[0,0,0,1] b5, then features 10,20,30,40 -> scores 10,20,45; out_valid at T+16, out_class=2, out_score=45; busy falls the cycle after.
2. Tie check: c0=c1=c2=[1,0,0,0] with all biases 0, then features 7,0,0,0 -> out_class=0, out_score=7.
3. Saturation check with all weights 32767 and biases 0:
   - features 32767 x4 -> out_score=32767;
   - reload weights as -32768 -> out_score=-32768.
4. in_valid burst before any weight load -> no out_valid within 40 cycles; busy stays 0, weights_ready stays 0.
5. Two features, then in_valid low for 1 cycle, then a full burst of 10,20,30,40 (test 1 weights) -> exactly one out_valid, with class 2 and score 45.
6. rst_n asserted at cycle T+5 of test 1 -> all outputs 0 the next cycle, no out_valid, weights_ready=0; a subsequent feature burst is ignored.
